// File: rtl/fitness_eval_seq.sv
// Sequential lattice fitness evaluator: one site per cycle, adding the site's self
// energy plus its right-neighbour interaction, saturating at the FIT_WIDTH maximum.
module fitness_eval_seq #(
  parameter int NUM_PARTICLE_TYPE = 3,
  parameter int DATA_WIDTH        = 4,
  parameter int TYPE_WIDTH        = 2,
  parameter int LATTICE_LENGTH    = 11,
  parameter int FIT_WIDTH         = 10,
  parameter int WRAP_EN           = 0
) (
  input  logic                                             clk_i,
  input  logic                                             rst_n,
  input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]          self_energy_vec_i,
  input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_i,
  input  logic [LATTICE_LENGTH*TYPE_WIDTH-1:0]             individual_vec_i,
  input  logic                                             in_valid_i,
  output logic                                             in_ready_o,
  output logic                                             out_valid_o,
  input  logic                                             out_ready_i,
  output logic [FIT_WIDTH-1:0]                             self_fit_o,
  output logic                                             overflow_o,
  output logic                                             type_err_o
);

  // state | meaning
  // IDLE  | waiting for a job, in_ready_o high
  // ACC   | accumulating one lattice site per cycle
  // DONE  | result valid, waiting for out_ready_i
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam int SW = ((FIT_WIDTH > DATA_WIDTH) ? FIT_WIDTH : DATA_WIDTH) + 2;
  localparam int IW = $clog2(LATTICE_LENGTH);
  localparam logic [SW-1:0] SAT = {{(SW-FIT_WIDTH){1'b0}}, {FIT_WIDTH{1'b1}}};

  state_t state, state_nxt;

  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]                   self_q;
  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] j_q;
  logic [LATTICE_LENGTH*TYPE_WIDTH-1:0]                      ind_q;
  logic [IW-1:0]                                             idx;

  logic                  accept, last;
  logic [TYPE_WIDTH-1:0] t_cur, t_nbr;
  logic                  cur_ok, nbr_ok, has_pair;
  logic [DATA_WIDTH-1:0] self_term, pair_term;
  logic [SW-1:0]         sum;
  int                    nbr_i;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign accept      = in_valid_i & in_ready_o;
  assign last        = (idx == IW'(LATTICE_LENGTH-1));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC;
      ACC:     if (last) state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range types contribute nothing to either their self or pair terms.
  always_comb begin
    nbr_i     = last ? 0 : int'(idx) + 1;
    t_cur     = ind_q[int'(idx)*TYPE_WIDTH +: TYPE_WIDTH];
    t_nbr     = ind_q[nbr_i*TYPE_WIDTH +: TYPE_WIDTH];
    cur_ok    = int'(t_cur) < NUM_PARTICLE_TYPE;
    nbr_ok    = int'(t_nbr) < NUM_PARTICLE_TYPE;
    has_pair  = !last || (WRAP_EN != 0);
    self_term = '0;
    pair_term = '0;
    if (cur_ok)
      self_term = self_q[int'(t_cur)*DATA_WIDTH +: DATA_WIDTH];
    if (has_pair && cur_ok && nbr_ok)
      pair_term = j_q[(int'(t_cur)*NUM_PARTICLE_TYPE + int'(t_nbr))*DATA_WIDTH +: DATA_WIDTH];
    sum = SW'(self_fit_o) + SW'(self_term) + SW'(pair_term);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      self_q     <= '0;
      j_q        <= '0;
      ind_q      <= '0;
      idx        <= '0;
      self_fit_o <= '0;
      overflow_o <= 1'b0;
      type_err_o <= 1'b0;
    end else if (accept) begin
      self_q     <= self_energy_vec_i;
      j_q        <= interact_matrix_i;
      ind_q      <= individual_vec_i;
      idx        <= '0;
      self_fit_o <= '0;
      overflow_o <= 1'b0;
      type_err_o <= 1'b0;
    end else if (state == ACC) begin
      if (sum > SAT) begin
        self_fit_o <= {FIT_WIDTH{1'b1}};
        overflow_o <= 1'b1;
      end else begin
        self_fit_o <= sum[FIT_WIDTH-1:0];
      end
      if (!cur_ok) type_err_o <= 1'b1;
      if (!last)   idx <= idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_fitness_eval_seq.sv
// Bench for fitness_eval_seq: three instances (default, wrap, narrow fitness) share stimulus
// and are checked against a per-site arithmetic model plus a directed table.
module tb_fitness_eval_seq;
  localparam int L = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] self_v = '0;
  logic [35:0] jm_v = '0;
  logic [21:0] ind_v = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  rdy, ov, ovf, err;
  logic [9:0]  fit0, fit1;
  logic [5:0]  fit2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fitness_eval_seq u_def (
    .clk_i(clk), .rst_n(rst_n), .self_energy_vec_i(self_v), .interact_matrix_i(jm_v),
    .individual_vec_i(ind_v), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .out_valid_o(ov[0]), .out_ready_i(out_ready), .self_fit_o(fit0),
    .overflow_o(ovf[0]), .type_err_o(err[0]));

  fitness_eval_seq #(.WRAP_EN(1)) u_wrap (
    .clk_i(clk), .rst_n(rst_n), .self_energy_vec_i(self_v), .interact_matrix_i(jm_v),
    .individual_vec_i(ind_v), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .out_valid_o(ov[1]), .out_ready_i(out_ready), .self_fit_o(fit1),
    .overflow_o(ovf[1]), .type_err_o(err[1]));

  fitness_eval_seq #(.FIT_WIDTH(6)) u_fw6 (
    .clk_i(clk), .rst_n(rst_n), .self_energy_vec_i(self_v), .interact_matrix_i(jm_v),
    .individual_vec_i(ind_v), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
    .out_valid_o(ov[2]), .out_ready_i(out_ready), .self_fit_o(fit2),
    .overflow_o(ovf[2]), .type_err_o(err[2]));

  typedef struct {
    logic [21:0] ind;
    int          fit;
    int          fit_wrap;
    int          fit6;
    bit          ovf6;
    bit          err;
  } vec_t;

  vec_t        tbl[5];
  logic [11:0] self_std;
  logic [35:0] j_std;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Whole-lattice energy from the defining sums; saturation is the clamp of the total.
  function automatic void model(input logic [21:0] ind, input logic [11:0] sv,
                                input logic [35:0] jm, input bit wrap, input int fw,
                                output int fit, output bit o, output bit e);
    int total = 0;
    int mx, a, b;
    e = 1'b0;
    for (int k = 0; k < L; k++) begin
      a = int'(ind[k*2 +: 2]);
      if (a >= 3) e = 1'b1;
      else total += int'(sv[a*4 +: 4]);
    end
    for (int k = 0; k < (wrap ? L : L-1); k++) begin
      a = int'(ind[k*2 +: 2]);
      b = int'(ind[((k+1)%L)*2 +: 2]);
      if (a < 3 && b < 3) total += int'(jm[(a*3+b)*4 +: 4]);
    end
    mx  = (1 << fw) - 1;
    o   = total > mx;
    fit = o ? mx : total;
  endfunction

  task automatic run_job(input logic [21:0] ind, input logic [11:0] sv,
                         input logic [35:0] jm, input int hold);
    int c;
    int f0, f1, f2;
    bit o0, o1, o2, e0, e1, e2;
    model(ind, sv, jm, 1'b0, 10, f0, o0, e0);
    model(ind, sv, jm, 1'b1, 10, f1, o1, e1);
    model(ind, sv, jm, 1'b0, 6,  f2, o2, e2);
    c = 0;
    while (!rdy[0] && c < 50) begin @(posedge clk); #1; c++; end
    chk("ready_before_accept", int'(rdy), 7);
    ind_v = ind; self_v = sv; jm_v = jm; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ind_v = 22'($urandom); self_v = 12'($urandom); jm_v = 36'({$urandom, $urandom});
    c = 0;
    while (!ov[0] && c < 50) begin @(posedge clk); #1; c++; end
    chk("latency", c, L);
    chk("valid_all", int'(ov), 7);
    chk("fit_def", int'(fit0), f0);
    chk("ovf_def", int'(ovf[0]), int'(o0));
    chk("err_def", int'(err[0]), int'(e0));
    chk("fit_wrap", int'(fit1), f1);
    chk("ovf_wrap", int'(ovf[1]), int'(o1));
    chk("fit_fw6", int'(fit2), f2);
    chk("ovf_fw6", int'(ovf[2]), int'(o2));
    chk("err_fw6", int'(err[2]), int'(e2));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; ind_v = 22'($urandom); self_v = 12'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", int'(ov[0]), 1);
      chk("hold_ready", int'(rdy[0]), 0);
      chk("hold_fit", int'(fit0), f0);
      chk("hold_flags", int'({ovf[2], err[0]}), int'({o2, e0}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_valid", int'(ov), 0);
    chk("idle_ready", int'(rdy[0]), 1);
    chk("retain_fit", int'(fit0), f0);
    chk("retain_err", int'(err[0]), int'(e0));
  endtask

  initial begin
    int seen;
    logic [21:0] alt;
    self_std = 12'h321;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        j_std[(a*3+b)*4 +: 4] = 4'(a + b + 1);
    alt = '0;
    for (int k = 0; k < L; k++) alt[k*2 +: 2] = 2'(k % 2);

    tbl[0] = '{22'h0,          21, 22, 21, 1'b0, 1'b0};
    tbl[1] = '{alt,            36, 37, 36, 1'b0, 1'b0};
    tbl[2] = '{{11{2'b10}},    83, 88, 63, 1'b1, 1'b0};
    tbl[3] = '{22'h000C00,     18, 19, 18, 1'b0, 1'b1};
    tbl[4] = '{{11{2'b11}},     0,  0,  0, 1'b0, 1'b1};

    #1;
    chk("reset_valid", int'(ov), 0);
    chk("reset_fit", int'(fit0), 0);
    chk("reset_flags", int'({ovf, err}), 0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", int'(rdy), 7);

    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i].ind, self_std, j_std, (i == 0) ? 5 : 0);
      chk("tbl_fit", int'(fit0), tbl[i].fit);
      chk("tbl_fit_wrap", int'(fit1), tbl[i].fit_wrap);
      chk("tbl_fit6", int'(fit2), tbl[i].fit6);
      chk("tbl_ovf6", int'(ovf[2]), int'(tbl[i].ovf6));
      chk("tbl_ovf_def", int'(ovf[0]), 0);
      chk("tbl_err", int'(err[0]), int'(tbl[i].err));
    end

    // Reset at ACC edge 4 of an all-type-2 job (partial sum is nonzero there).
    ind_v = {11{2'b10}}; self_v = self_std; jm_v = j_std; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_partial", int'(fit0), 32);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(ov), 0);
    chk("abort_fit", int'(fit0) + int'(fit1) + int'(fit2), 0);
    chk("abort_flags", int'({ovf, err}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ov != 3'b000) seen++;
    end
    out_ready = 1'b0;
    chk("no_valid_after_abort", seen, 0);
    chk("ready_after_abort", int'(rdy), 7);
    run_job(tbl[1].ind, self_std, j_std, 1);
    chk("post_abort_fit", int'(fit0), 36);

    for (int n = 0; n < 30; n++)
      run_job(22'($urandom), 12'($urandom), 36'({$urandom, $urandom}),
              int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
